// File: rtl/mac_filter.sv
// Receive MAC filter: matches dest MAC / ethertype, strips the header
// and forwards payload+FCS one cycle late, counting accepts and drops.
module mac_filter #(
  parameter int          DW        = 2,
  parameter logic [47:0] ME        = 48'h69695A065491,
  parameter logic [47:0] ALT_MAC   = 48'h000000000000,
  parameter bit          ACCEPT_MC = 1'b0,
  parameter bit          ETYPE_EN  = 1'b0,
  parameter logic [15:0] ETYPE     = 16'h88B5,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          promisc,
  input  logic          axiiv,
  input  logic [DW-1:0] axiid,
  output logic          axiov,
  output logic [DW-1:0] axiod,
  output logic          accept_p,
  output logic          drop_p,
  output logic [15:0]   accept_cnt,
  output logic [15:0]   drop_cnt
);

  localparam int DB      = 48 / DW;
  localparam int SB      = 2 * DB;
  localparam int HB      = 112 / DW;
  localparam int MC_BEAT = 7 / DW;
  localparam int MC_BIT  = DW * (MC_BEAT + 1) - 8;
  localparam bit ALT_EN  = (ALT_MAC != 48'd0);

  typedef enum logic [2:0] {
    SKIP, IDLE, DEST, SRC, ETYP, PASS, DROP
  } state_t;

  state_t st, st_n;

  logic [7:0] b, b_n;
  logic me_f, alt_f, bc_f, mc_f, et_f, pr_f;
  logic me_n, alt_n, bc_n, mc_n, et_n, pr_n;
  logic acc_n, drp_n, ov_n;
  logic [DW-1:0] od_n;
  logic [CNT_W-1:0] acc_q, drp_q;

  function automatic logic [DW-1:0] seg48(
    input logic [47:0] v,
    input int          k
  );
    logic [47:0] s;
    if (k < 0 || k >= DB) return '0;
    s = v >> (48 - DW * (k + 1));
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] seg16(
    input logic [15:0] v,
    input int          k
  );
    logic [15:0] s;
    if (k < 0 || k >= 16 / DW) return '0;
    s = v >> (16 - DW * (k + 1));
    return s[DW-1:0];
  endfunction

  // b is held at 0 in IDLE, so the first beat uses segment 0
  logic first;
  logic me_now, alt_now, bc_now, mc_now;
  logic et_now, dest_ok;

  assign first   = (st == IDLE);
  assign me_now  = (first | me_f)
                 & (axiid == seg48(ME, int'(b)));
  assign alt_now = (first | alt_f)
                 & (axiid == seg48(ALT_MAC, int'(b)));
  assign bc_now  = (first | bc_f) & (&axiid);
  assign mc_now  = (int'(b) == MC_BEAT)
                 ? axiid[MC_BIT]
                 : (mc_f & ~first);
  assign et_now  = ((int'(b) == SB) | et_f)
                 & (axiid == seg16(ETYPE, int'(b) - SB));
  assign dest_ok = me_now | (ALT_EN & alt_now)
                 | bc_now | (ACCEPT_MC & mc_now)
                 | pr_f;

  always_comb begin
    st_n  = st;
    b_n   = b;
    me_n  = me_f;
    alt_n = alt_f;
    bc_n  = bc_f;
    mc_n  = mc_f;
    et_n  = et_f;
    pr_n  = pr_f;
    acc_n = 1'b0;
    drp_n = 1'b0;
    ov_n  = 1'b0;
    od_n  = '0;
    unique case (st)
      SKIP: begin
        if (!axiiv) st_n = IDLE;
      end
      IDLE: begin
        if (axiiv) begin
          st_n  = DEST;
          b_n   = 8'd1;
          pr_n  = promisc;
          me_n  = me_now;
          alt_n = alt_now;
          bc_n  = bc_now;
          mc_n  = mc_now;
        end
      end
      DEST: begin
        if (!axiiv) begin
          st_n  = IDLE;
          b_n   = '0;
          drp_n = 1'b1;
        end else begin
          b_n   = b + 8'd1;
          me_n  = me_now;
          alt_n = alt_now;
          bc_n  = bc_now;
          mc_n  = mc_now;
          if (int'(b) == DB - 1) begin
            st_n  = dest_ok ? SRC : DROP;
            drp_n = ~dest_ok;
          end
        end
      end
      SRC: begin
        if (!axiiv) begin
          st_n  = IDLE;
          b_n   = '0;
          drp_n = 1'b1;
        end else begin
          b_n = b + 8'd1;
          if (int'(b) == SB - 1) st_n = ETYP;
        end
      end
      ETYP: begin
        if (!axiiv) begin
          st_n  = IDLE;
          b_n   = '0;
          drp_n = 1'b1;
        end else begin
          b_n  = b + 8'd1;
          et_n = et_now;
          if (int'(b) == HB - 1) begin
            if (!ETYPE_EN || et_now) begin
              st_n  = PASS;
              acc_n = 1'b1;
            end else begin
              st_n  = DROP;
              drp_n = 1'b1;
            end
          end
        end
      end
      PASS: begin
        if (axiiv) begin
          ov_n = 1'b1;
          od_n = axiid;
        end else begin
          st_n = IDLE;
          b_n  = '0;
        end
      end
      DROP: begin
        if (!axiiv) begin
          st_n = IDLE;
          b_n  = '0;
        end
      end
      default: st_n = SKIP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= SKIP;
      b        <= '0;
      me_f     <= 1'b0;
      alt_f    <= 1'b0;
      bc_f     <= 1'b0;
      mc_f     <= 1'b0;
      et_f     <= 1'b0;
      pr_f     <= 1'b0;
      axiov    <= 1'b0;
      axiod    <= '0;
      accept_p <= 1'b0;
      drop_p   <= 1'b0;
      acc_q    <= '0;
      drp_q    <= '0;
    end else begin
      st       <= st_n;
      b        <= b_n;
      me_f     <= me_n;
      alt_f    <= alt_n;
      bc_f     <= bc_n;
      mc_f     <= mc_n;
      et_f     <= et_n;
      pr_f     <= pr_n;
      axiov    <= ov_n;
      axiod    <= od_n;
      accept_p <= acc_n;
      drop_p   <= drp_n;
      if (acc_n && acc_q != {CNT_W{1'b1}})
        acc_q <= acc_q + 1'b1;
      if (drp_n && drp_q != {CNT_W{1'b1}})
        drp_q <= drp_q + 1'b1;
    end
  end

  assign accept_cnt = 16'(acc_q);
  assign drop_cnt   = 16'(drp_q);

endmodule

// File: tb/tb_mac_filter.sv
// Bench for mac_filter: directed scenarios plus random frames on a
// DW=2 default instance and a DW=8 ethertype/multicast instance.
module tb_mac_filter;

  localparam logic [47:0] ME   = 48'h69695A065491;
  localparam logic [47:0] ALTB = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;
  localparam int MAXA = 65535;
  localparam int MAXB = 31;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       promisc_a, axiiv_a, axiov_a;
  logic [1:0] axiid_a, axiod_a;
  logic       accept_p_a, drop_p_a;
  logic [15:0] accept_cnt_a, drop_cnt_a;

  logic       promisc_b, axiiv_b, axiov_b;
  logic [7:0] axiid_b, axiod_b;
  logic       accept_p_b, drop_p_b;
  logic [15:0] accept_cnt_b, drop_cnt_b;

  mac_filter #(.DW(2)) u_a (
    .clk(clk), .rst_n(rst_n), .promisc(promisc_a),
    .axiiv(axiiv_a), .axiid(axiid_a),
    .axiov(axiov_a), .axiod(axiod_a),
    .accept_p(accept_p_a), .drop_p(drop_p_a),
    .accept_cnt(accept_cnt_a), .drop_cnt(drop_cnt_a)
  );

  mac_filter #(
    .DW(8), .ALT_MAC(ALTB), .ACCEPT_MC(1'b1),
    .ETYPE_EN(1'b1), .ETYPE(16'h88B5), .CNT_W(5)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .promisc(promisc_b),
    .axiiv(axiiv_b), .axiid(axiid_b),
    .axiov(axiov_b), .axiod(axiod_b),
    .accept_p(accept_p_b), .drop_p(drop_p_b),
    .accept_cnt(accept_cnt_b), .drop_cnt(drop_cnt_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] oq_a[$];
  logic [7:0] oq_b[$];
  int nacc[2], ndrp[2], both[2], zerr[2];
  int fov[2], acyc[2], dcyc[2];
  bit pov[2];

  always @(negedge clk) begin
    if (axiov_a) begin
      oq_a.push_back({6'd0, axiod_a});
      if (!pov[0]) fov[0] = cyc;
    end else if (axiod_a !== 2'd0) zerr[0]++;
    pov[0] = axiov_a;
    if (axiov_b) begin
      oq_b.push_back(axiod_b);
      if (!pov[1]) fov[1] = cyc;
    end else if (axiod_b !== 8'd0) zerr[1]++;
    pov[1] = axiov_b;
    if (accept_p_a) begin nacc[0]++; acyc[0] = cyc; end
    if (drop_p_a) begin ndrp[0]++; dcyc[0] = cyc; end
    if (accept_p_b) begin nacc[1]++; acyc[1] = cyc; end
    if (drop_p_b) begin ndrp[1]++; dcyc[1] = cyc; end
    if (accept_p_a && drop_p_a) both[0]++;
    if (accept_p_b && drop_p_b) both[1]++;
  end

  int nasrt = 0;
  int nfail = 0;
  int mc_acc[2], mc_drp[2];
  int s_acc[2], s_drp[2], s_oq[2];
  int hl_cyc, dl_cyc, end_cyc;
  bit frm[$];
  logic [7:0] expq[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] d,
                       input logic [47:0] s,
                       input logic [15:0] et,
                       input int npay);
    frm.delete();
    for (int i = 47; i >= 0; i--) frm.push_back(d[i]);
    for (int i = 47; i >= 0; i--) frm.push_back(s[i]);
    for (int i = 15; i >= 0; i--) frm.push_back(et[i]);
    for (int i = 0; i < npay; i++)
      frm.push_back(1'($urandom_range(0, 1)));
  endtask

  function automatic logic [7:0] beat(input int dw,
                                      input int i);
    logic [7:0] v;
    v = '0;
    for (int j = 0; j < dw; j++) v[dw-1-j] = frm[i*dw+j];
    return v;
  endfunction

  function automatic bit model_acc(input int w,
                                   input logic [47:0] d,
                                   input logic [15:0] et,
                                   input bit pr,
                                   input int nb);
    if (nb < (w ? 14 : 56)) return 1'b0;
    if (w == 0) return pr || d == ME || d == BC;
    return (pr || d == ME || d == ALTB || d == BC || d[40])
           && et == 16'h88B5;
  endfunction

  task automatic mkexp(input int w, input int nb,
                       input bit acc);
    int dw;
    dw = w ? 8 : 2;
    expq.delete();
    if (acc)
      for (int i = 112 / dw; i < nb; i++)
        expq.push_back(beat(dw, i));
  endtask

  task automatic bump(input int w, input bit acc);
    int mx;
    mx = w ? MAXB : MAXA;
    if (acc) begin
      if (mc_acc[w] < mx) mc_acc[w]++;
    end else if (mc_drp[w] < mx) mc_drp[w]++;
  endtask

  task automatic snap();
    for (int w = 0; w < 2; w++) begin
      s_acc[w] = nacc[w];
      s_drp[w] = ndrp[w];
    end
    s_oq[0] = oq_a.size();
    s_oq[1] = oq_b.size();
  endtask

  task automatic send(input int w, input int nb,
                      input bit pr0, input bit tog,
                      input int rst_beat);
    int dw, db, hb;
    logic [7:0] v;
    bit pv;
    dw = w ? 8 : 2;
    db = 48 / dw;
    hb = 112 / dw;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      v  = beat(dw, i);
      pv = (i == 0 || !tog) ? pr0 : 1'($urandom_range(0, 1));
      if (w == 0) begin
        axiiv_a = 1'b1; axiid_a = v[1:0]; promisc_a = pv;
      end else begin
        axiiv_b = 1'b1; axiid_b = v; promisc_b = pv;
      end
      if (i == db - 1) dl_cyc = cyc;
      if (i == hb - 1) hl_cyc = cyc;
      if (i == rst_beat) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_axiov", {63'd0, axiov_a}, 64'd0);
        chk("rst_axiod", {62'd0, axiod_a}, 64'd0);
      end
      if (i == rst_beat + 2) rst_n = 1'b1;
    end
    @(negedge clk);
    axiiv_a = 1'b0; axiid_a = '0;
    axiiv_b = 1'b0; axiid_b = '0;
    end_cyc = cyc;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_res(input string tag, input int w,
                           input int ea, input int ed);
    int no, mism;
    logic [7:0] o;
    chk({tag, " accepts"}, 64'(nacc[w] - s_acc[w]), 64'(ea));
    chk({tag, " drops"}, 64'(ndrp[w] - s_drp[w]), 64'(ed));
    no = (w ? oq_b.size() : oq_a.size()) - s_oq[w];
    chk({tag, " beats"}, 64'(no), 64'(expq.size()));
    mism = 0;
    for (int k = 0; k < expq.size() && k < no; k++) begin
      o = w ? oq_b[s_oq[w]+k] : oq_a[s_oq[w]+k];
      if (o !== expq[k]) mism++;
    end
    chk({tag, " data_mismatches"}, 64'(mism), 64'd0);
    chk({tag, " accept_cnt"},
        64'(w ? accept_cnt_b : accept_cnt_a), 64'(mc_acc[w]));
    chk({tag, " drop_cnt"},
        64'(w ? drop_cnt_b : drop_cnt_a), 64'(mc_drp[w]));
    chk({tag, " zero_when_invalid"}, 64'(zerr[w]), 64'd0);
    chk({tag, " pulse_exclusive"}, 64'(both[w]), 64'd0);
  endtask

  initial begin
    int rc;
    promisc_a = 0; axiiv_a = 0; axiid_a = '0;
    promisc_b = 0; axiiv_b = 0; axiid_b = '0;
    repeat (3) @(negedge clk);
    chk("reset axiov_a", 64'(axiov_a), 64'd0);
    chk("reset axiod_a", 64'(axiod_a), 64'd0);
    chk("reset accept_p_a", 64'(accept_p_a), 64'd0);
    chk("reset drop_p_a", 64'(drop_p_a), 64'd0);
    chk("reset accept_cnt_a", 64'(accept_cnt_a), 64'd0);
    chk("reset drop_cnt_a", 64'(drop_cnt_a), 64'd0);
    chk("reset axiov_b", 64'(axiov_b), 64'd0);
    chk("reset axiod_b", 64'(axiod_b), 64'd0);
    chk("reset accept_p_b", 64'(accept_p_b), 64'd0);
    chk("reset drop_p_b", 64'(drop_p_b), 64'd0);
    chk("reset accept_cnt_b", 64'(accept_cnt_b), 64'd0);
    chk("reset drop_cnt_b", 64'(drop_cnt_b), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // dest = ME, 20 payload dibits
    snap();
    build(ME, 48'h001122334455, 16'h0800, 40);
    send(0, 76, 1'b0, 1'b0, -1);
    settle();
    mkexp(0, 76, 1'b1);
    bump(0, 1'b1);
    check_res("t1", 0, 1, 0);
    chk("t1 accept_cycle", 64'(acyc[0]), 64'(hl_cyc + 1));
    chk("t1 first_out_cycle", 64'(fov[0]), 64'(hl_cyc + 2));

    // foreign unicast, promisc toggling mid-frame is ignored
    snap();
    build(48'h020000000001, 48'h0A0000000002, 16'h0800, 20);
    send(0, 66, 1'b0, 1'b1, -1);
    settle();
    mkexp(0, 66, 1'b0);
    bump(0, 1'b0);
    check_res("t2 drop", 0, 0, 1);
    chk("t2 drop_cycle", 64'(dcyc[0]), 64'(dl_cyc + 1));
    snap();
    build(48'h020000000001, 48'h0A0000000002, 16'h0800, 20);
    send(0, 66, 1'b1, 1'b1, -1);
    settle();
    mkexp(0, 66, 1'b1);
    bump(0, 1'b1);
    check_res("t2 promisc", 0, 1, 0);

    // broadcast with ethertype filter
    snap();
    build(BC, 48'h001122334455, 16'h0800, 64);
    send(1, 22, 1'b0, 1'b0, -1);
    settle();
    mkexp(1, 22, 1'b0);
    bump(1, 1'b0);
    check_res("t3 wrong_etype", 1, 0, 1);
    chk("t3 drop_cycle", 64'(dcyc[1]), 64'(hl_cyc + 1));
    snap();
    build(BC, 48'h001122334455, 16'h88B5, 64);
    send(1, 22, 1'b0, 1'b0, -1);
    settle();
    mkexp(1, 22, 1'b1);
    bump(1, 1'b1);
    check_res("t3 etype_ok", 1, 1, 0);
    chk("t3 accept_cycle", 64'(acyc[1]), 64'(hl_cyc + 1));

    // runt of 10 beats, next frame one idle cycle later
    snap();
    build(ME, 48'h001122334455, 16'h88B5, 0);
    send(1, 10, 1'b0, 1'b0, -1);
    rc = end_cyc;
    bump(1, 1'b0);
    build(ME, 48'h665544332211, 16'h88B5, 48);
    send(1, 20, 1'b0, 1'b0, -1);
    settle();
    mkexp(1, 20, 1'b1);
    bump(1, 1'b1);
    check_res("t4 runt_then_good", 1, 1, 1);
    chk("t4 runt_drop_cycle", 64'(dcyc[1]), 64'(rc + 1));

    // reset mid-payload, released while the frame is still on the wire
    snap();
    build(ME, 48'h001122334455, 16'h0800, 80);
    send(0, 96, 1'b0, 1'b0, 66);
    settle();
    mkexp(0, 66, 1'b1);
    mc_acc = '{0, 0};
    mc_drp = '{0, 0};
    check_res("t5 reset", 0, 1, 0);
    chk("t5 b_accept_cnt", 64'(accept_cnt_b), 64'd0);
    snap();
    build(ME, 48'h001122334455, 16'h0800, 24);
    send(0, 68, 1'b0, 1'b0, -1);
    settle();
    mkexp(0, 68, 1'b1);
    bump(0, 1'b1);
    check_res("t5 after", 0, 1, 0);

    // back-to-back runts drive the narrow counter into saturation
    snap();
    for (int f = 0; f < 40; f++) begin
      build({16'($urandom), 32'($urandom)}, 48'd0, 16'd0, 0);
      send(1, 1, 1'b0, 1'b0, -1);
      bump(1, 1'b0);
    end
    settle();
    expq.delete();
    check_res("t6 saturate", 1, 0, 40);
    chk("t6 drop_cnt_max", 64'(drop_cnt_b), 64'(MAXB));

    for (int f = 0; f < 24; f++) begin
      int w, dw, hb, nb, kind;
      logic [47:0] d;
      logic [15:0] et;
      bit pr, acc;
      w    = $urandom_range(0, 1);
      dw   = w ? 8 : 2;
      hb   = 112 / dw;
      kind = $urandom_range(0, 5);
      d    = {16'($urandom), 32'($urandom)};
      case (kind)
        0: d = ME;
        1: d = ALTB;
        2: d = BC;
        3: d[40] = 1'b0;
        4: d = ME ^ 48'h1;
        default: d[40] = 1'b1;
      endcase
      case ($urandom_range(0, 2))
        0: et = 16'h88B5;
        1: et = 16'h0800;
        default: et = 16'($urandom);
      endcase
      pr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) nb = $urandom_range(1, hb - 1);
      else nb = hb + $urandom_range(0, 12);
      build(d, {16'($urandom), 32'($urandom)}, et,
            (nb > hb) ? (nb - hb) * dw : 0);
      snap();
      send(w, nb, pr, 1'b1, -1);
      settle();
      acc = model_acc(w, d, et, pr, nb);
      mkexp(w, nb, acc);
      bump(w, acc);
      check_res("rand", w, int'(acc), int'(!acc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
